pe_schedule_controller: RTL and testbench
=========================================

# pe_schedule_controller

Top-level sequencer for one Eyeriss processing element. On a start request it runs the filter-load and ifmap-load phases by handshaking with the PE's filter and ifmap read controllers. It then sweeps the filter and ifmap scratchpads through the MAC unit, one 1-D convolution row at a time, and hands each finished partial sum to the psum path under a valid/ready handshake.

## Interface
Parameters:
- FILT_LEN, 4: filter taps per row; must be ≥1.
- IFMAP_LEN, 16: ifmap elements per row; must be ≥ FILT_LEN.
- STRIDE, 1: window step; must be ≥1.
- ADDR_W, 4: scratchpad address width; 2^ADDR_W must be ≥ IFMAP_LEN.
- Derived: NOUT = (IFMAP_LEN − FILT_LEN)/STRIDE + 1 (integer division).

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst, in, 1: reset, synchronous, active-high.
- start, in, 1: begin one PE pass; sampled only in IDLE.
- filt_done, in, 1: filter read controller finished (level).
- ifmap_done, in, 1: ifmap read controller finished (level).
- psum_ready, in, 1: psum consumer accepts.
- start_filt, out, 1: one-cycle pulse that starts the filter read controller.
- start_ifmap, out, 1: one-cycle pulse that starts the ifmap read controller.
- rd_clr, out, 1: one-cycle pulse that returns both read controllers to idle.
- filt_addr, out, ADDR_W: filter scratchpad read address.
- ifmap_addr, out, ADDR_W: ifmap scratchpad read address.
- mac_en, out, 1: MAC accumulate enable.
- acc_clr, out, 1: accumulator load (replace, not add) on this MAC cycle.
- psum_valid, out, 1: accumulator holds a finished psum.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at the end of the pass.

## Operation
- States: IDLE, LOAD_F, LOAD_I, MAC, DRAIN, OUT, DONE. ps register reset to IDLE; counters k (tap) and o (output) reset to 0.
- IDLE: go to LOAD_F if start.
- LOAD_F: start_filt=1 on the first cycle only; go to LOAD_I when filt_done=1.
- LOAD_I: start_ifmap=1 on the first cycle only; go to MAC when ifmap_done=1; clear k and o on exit.
- MAC: mac_en=1, acc_clr=(k==0), filt_addr=k, ifmap_addr=o*STRIDE+k.
  - If k==FILT_LEN−1, go to DRAIN with k←0; otherwise k←k+1.
- DRAIN: one cycle for the 1-cycle MAC latency; all enables low; go to OUT.
- OUT: psum_valid=1.
  - When psum_ready=1: if o==NOUT−1 go to DONE, otherwise o←o+1 and go to MAC.
- DONE: done=1, rd_clr=1; go to IDLE.
- Outputs are Moore, decoded from ps and counters. Every output is 0 in IDLE and after reset; addresses read 0 outside MAC.
- Address arithmetic is unsigned, computed at ADDR_W+1 bits, and truncated to ADDR_W. The parameter rules guarantee no overflow.

## Timing
- start→start_filt: 1 cycle, i.e. start_filt is high on the first cycle in LOAD_F.
- filt_done already high on LOAD_F entry: one LOAD_F cycle, then LOAD_I. ifmap_done behaves the same way in LOAD_I.
- Per output with psum_ready held high: FILT_LEN MAC cycles, plus 1 DRAIN, plus 1 OUT.
- Total pass, with both done inputs returning on the entry cycle and psum_ready high: 1 + 1 + NOUT·(FILT_LEN+2) + 1 cycles from start-sampled to the done pulse.
- Stall in OUT: psum_valid stays high, counters hold, mac_en stays 0, for as long as psum_ready=0.
- start while busy: ignored. start held high through DONE: a new pass begins on the IDLE cycle that follows.
- rst at any cycle: next state IDLE, counters 0, all outputs 0 on the following cycle. No done pulse and no rd_clr is issued.
- FILT_LEN=1: every MAC cycle has acc_clr=1 and lasts one cycle. NOUT=1: OUT goes straight to DONE.

## Test plan
- FILT_LEN=3, IFMAP_LEN=5, STRIDE=1, done inputs tied high, psum_ready=1; start pulse:
  - (filt_addr, ifmap_addr) sequence is (0,0)(1,1)(2,2), (0,1)(1,2)(2,3), (0,2)(1,3)(2,4).
  - acc_clr is high on taps 0; three psum_valid pulses; done 18 cycles after start-sampled.
- STRIDE=2, IFMAP_LEN=7, FILT_LEN=3 -> NOUT=3; window base ifmap_addr values are 0, 2, 4; the last address is 6.
- filt_done delayed 5 cycles and ifmap_done delayed 3 cycles -> start_filt and start_ifmap are exactly one cycle each; MAC starts on the cycle after ifmap_done is seen.
- psum_ready low for 4 cycles on output 1 -> psum_valid high for 5 cycles; no mac_en pulses meanwhile; the address sequence after the stall is unchanged.
- rst asserted during the second MAC cycle -> all outputs 0 on the next cycle; a following start replays the full pass from start_filt.
- start re-pulsed during LOAD_I and OUT -> no effect. done and rd_clr coincide for exactly one cycle; busy falls on the cycle after.

Source files
------------

// File: rtl/pe_schedule_controller.sv
// Eyeriss PE pass sequencer: loads the filter and ifmap scratchpads through
// their read controllers, then sweeps 1-D convolution windows through the
// MAC and hands each finished psum downstream under valid/ready.
module pe_schedule_controller #(
  parameter int FILT_LEN  = 4,
  parameter int IFMAP_LEN = 16,
  parameter int STRIDE    = 1,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              filt_done,
  input  logic              ifmap_done,
  input  logic              psum_ready,
  output logic              start_filt,
  output logic              start_ifmap,
  output logic              rd_clr,
  output logic [ADDR_W-1:0] filt_addr,
  output logic [ADDR_W-1:0] ifmap_addr,
  output logic              mac_en,
  output logic              acc_clr,
  output logic              psum_valid,
  output logic              busy,
  output logic              done
);

  localparam int NOUT = (IFMAP_LEN - FILT_LEN) / STRIDE + 1;
  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(FILT_LEN - 1);
  localparam logic [ADDR_W-1:0] O_LAST   = ADDR_W'(NOUT - 1);
  localparam logic [ADDR_W:0]   STRIDE_W = (ADDR_W + 1)'(STRIDE);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_F, S_LOAD_I, S_MAC, S_DRAIN, S_OUT, S_DONE
  } state_t;

  state_t            r_ps, w_ns;
  logic [ADDR_W-1:0] r_k, r_o, w_k_nxt, w_o_nxt;
  logic              r_first;   // first cycle after any state change
  logic [ADDR_W:0]   w_ifa;

  // Window base plus tap, one bit wider than the scratchpad address.
  assign w_ifa = ({1'b0, r_o} * STRIDE_W) + {1'b0, r_k};

  // State, tap/output counters and state-entry flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ps    <= S_IDLE;
      r_k     <= '0;
      r_o     <= '0;
      r_first <= 1'b0;
    end else begin
      r_ps    <= w_ns;
      r_k     <= w_k_nxt;
      r_o     <= w_o_nxt;
      r_first <= (w_ns != r_ps);
    end
  end

  // Next state, counter updates and Moore outputs.
  always_comb begin
    w_ns        = r_ps;
    w_k_nxt     = r_k;
    w_o_nxt     = r_o;
    start_filt  = 1'b0;
    start_ifmap = 1'b0;
    rd_clr      = 1'b0;
    filt_addr   = '0;
    ifmap_addr  = '0;
    mac_en      = 1'b0;
    acc_clr     = 1'b0;
    psum_valid  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_ps)
      S_IDLE: begin
        if (start) w_ns = S_LOAD_F;
      end
      S_LOAD_F: begin
        busy       = 1'b1;
        start_filt = r_first;
        if (filt_done) w_ns = S_LOAD_I;
      end
      S_LOAD_I: begin
        busy        = 1'b1;
        start_ifmap = r_first;
        if (ifmap_done) begin
          w_ns    = S_MAC;
          w_k_nxt = '0;
          w_o_nxt = '0;
        end
      end
      S_MAC: begin
        busy       = 1'b1;
        mac_en     = 1'b1;
        acc_clr    = (r_k == '0);
        filt_addr  = r_k;
        ifmap_addr = ADDR_W'(w_ifa);
        if (r_k == K_LAST) begin
          w_ns    = S_DRAIN;
          w_k_nxt = '0;
        end else begin
          w_k_nxt = r_k + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        // Covers the single-cycle MAC latency before the psum is final.
        busy = 1'b1;
        w_ns = S_OUT;
      end
      S_OUT: begin
        busy       = 1'b1;
        psum_valid = 1'b1;
        if (psum_ready) begin
          if (r_o == O_LAST) begin
            w_ns = S_DONE;
          end else begin
            w_o_nxt = r_o + ADDR_W'(1);
            w_ns    = S_MAC;
          end
        end
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        rd_clr = 1'b1;
        w_ns   = S_IDLE;
      end
      default: w_ns = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_schedule_controller.sv
// Directed bench: three controller configurations (F3/I5/S1, F3/I7/S2,
// F1/I1/S1) driven one at a time through a shared stimulus/monitor loop.
module tb_pe_schedule_controller;

  logic clk, rst, start, filt_done, ifmap_done, psum_ready;
  logic start0, start1, start2;
  int   sel;

  logic sf0, si0, rc0, me0, ac0, pv0, bz0, dn0; logic [3:0] fa0, ia0;
  logic sf1, si1, rc1, me1, ac1, pv1, bz1, dn1; logic [3:0] fa1, ia1;
  logic sf2, si2, rc2, me2, ac2, pv2, bz2, dn2; logic [0:0] fa2, ia2;
  logic m_sf, m_si, m_rc, m_me, m_ac, m_pv, m_bz, m_dn; logic [3:0] m_fa, m_ia;

  int passed, total;
  int sf_cnt, si_cnt, sf_cyc, si_cyc, mac_first, pv_cnt, pv_rise, pv_max;
  int done_cnt, done_cyc, rc_bad, busy_after, mac_stall_bad;
  int qf[$], qi[$], qc[$];

  int ef[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int ei[9] = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
  int ei2[9] = '{0, 1, 2, 2, 3, 4, 4, 5, 6};
  int ec[9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};

  assign start0 = start && (sel == 0);
  assign start1 = start && (sel == 1);
  assign start2 = start && (sel == 2);

  pe_schedule_controller #(.FILT_LEN(3), .IFMAP_LEN(5), .STRIDE(1), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start0), .filt_done(filt_done), .ifmap_done(ifmap_done),
    .psum_ready(psum_ready), .start_filt(sf0), .start_ifmap(si0), .rd_clr(rc0),
    .filt_addr(fa0), .ifmap_addr(ia0), .mac_en(me0), .acc_clr(ac0), .psum_valid(pv0),
    .busy(bz0), .done(dn0));

  pe_schedule_controller #(.FILT_LEN(3), .IFMAP_LEN(7), .STRIDE(2), .ADDR_W(4)) dut_s2 (
    .clk(clk), .rst(rst), .start(start1), .filt_done(filt_done), .ifmap_done(ifmap_done),
    .psum_ready(psum_ready), .start_filt(sf1), .start_ifmap(si1), .rd_clr(rc1),
    .filt_addr(fa1), .ifmap_addr(ia1), .mac_en(me1), .acc_clr(ac1), .psum_valid(pv1),
    .busy(bz1), .done(dn1));

  pe_schedule_controller #(.FILT_LEN(1), .IFMAP_LEN(1), .STRIDE(1), .ADDR_W(1)) dut_f1 (
    .clk(clk), .rst(rst), .start(start2), .filt_done(filt_done), .ifmap_done(ifmap_done),
    .psum_ready(psum_ready), .start_filt(sf2), .start_ifmap(si2), .rd_clr(rc2),
    .filt_addr(fa2), .ifmap_addr(ia2), .mac_en(me2), .acc_clr(ac2), .psum_valid(pv2),
    .busy(bz2), .done(dn2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the selected instance to the monitor.
  always_comb begin
    case (sel)
      1: begin
        m_sf = sf1; m_si = si1; m_rc = rc1; m_me = me1; m_ac = ac1;
        m_pv = pv1; m_bz = bz1; m_dn = dn1; m_fa = fa1; m_ia = ia1;
      end
      2: begin
        m_sf = sf2; m_si = si2; m_rc = rc2; m_me = me2; m_ac = ac2;
        m_pv = pv2; m_bz = bz2; m_dn = dn2; m_fa = {3'b0, fa2}; m_ia = {3'b0, ia2};
      end
      default: begin
        m_sf = sf0; m_si = si0; m_rc = rc0; m_me = me0; m_ac = ac0;
        m_pv = pv0; m_bz = bz0; m_dn = dn0; m_fa = fa0; m_ia = ia0;
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one pass on the selected instance; start is driven in cycle 0.
  task automatic run_pass(input int fd_dly, input int id_dly, input int stall_out,
                          input int stall_n, input bit repulse);
    int stall_left;
    bit prev_pv;
    int pv_run;
    sf_cnt = 0; si_cnt = 0; sf_cyc = -1; si_cyc = -1; mac_first = -1;
    pv_cnt = 0; pv_rise = 0; pv_max = 0; done_cnt = 0; done_cyc = -1;
    rc_bad = 0; busy_after = -1; mac_stall_bad = 0;
    qf.delete(); qi.delete(); qc.delete();
    stall_left = stall_n; prev_pv = 1'b0; pv_run = 0;
    filt_done = 1'b0; ifmap_done = 1'b0; psum_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      start = 1'b0;
      if (m_sf) begin sf_cnt++; sf_cyc = c; end
      if (m_si) begin si_cnt++; si_cyc = c; end
      if (m_me) begin
        if (mac_first < 0) mac_first = c;
        qf.push_back(int'(m_fa)); qi.push_back(int'(m_ia)); qc.push_back(int'(m_ac));
      end
      if (m_pv) begin
        pv_cnt++;
        if (!prev_pv) pv_rise++;
        pv_run++;
        if (pv_run > pv_max) pv_max = pv_run;
      end else begin
        pv_run = 0;
      end
      if (m_pv && m_me) mac_stall_bad++;
      prev_pv = m_pv;
      if (m_rc != m_dn) rc_bad++;
      if (m_dn) begin
        done_cnt++; done_cyc = c;
        tick();
        busy_after = int'(m_bz);
        if (m_rc || m_dn) rc_bad++;
        break;
      end
      filt_done  = (sf_cyc > 0) && (c >= sf_cyc + fd_dly);
      ifmap_done = (si_cyc > 0) && (c >= si_cyc + id_dly);
      if (m_pv && pv_rise == stall_out && stall_left > 0) begin
        psum_ready = 1'b0; stall_left--;
      end else begin
        psum_ready = 1'b1;
      end
      if (repulse) start = m_si || m_pv;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; filt_done = 1'b0; ifmap_done = 1'b0; psum_ready = 1'b0;
    tick(); tick();
    total++; if ({sf0, si0, rc0, fa0, ia0, me0, ac0, pv0, bz0, dn0} !== '0)
      $display("FAIL reset_dut0 got %b exp 0", {sf0, si0, rc0, fa0, ia0, me0, ac0, pv0, bz0, dn0}); else passed++;
    total++; if ({sf1, si1, rc1, fa1, ia1, me1, ac1, pv1, bz1, dn1} !== '0)
      $display("FAIL reset_dut1 got %b exp 0", {sf1, si1, rc1, fa1, ia1, me1, ac1, pv1, bz1, dn1}); else passed++;
    total++; if ({sf2, si2, rc2, fa2, ia2, me2, ac2, pv2, bz2, dn2} !== '0)
      $display("FAIL reset_dut2 got %b exp 0", {sf2, si2, rc2, fa2, ia2, me2, ac2, pv2, bz2, dn2}); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    sel = 0;
    run_pass(0, 0, 0, 0, 1'b0);
    total++; if (sf_cyc !== 1) $display("FAIL basic_start_filt_cyc got %0d exp 1", sf_cyc); else passed++;
    total++; if (sf_cnt !== 1 || si_cnt !== 1)
      $display("FAIL basic_start_pulses got %0d/%0d exp 1/1", sf_cnt, si_cnt); else passed++;
    total++; if (mac_first !== 3) $display("FAIL basic_mac_first got %0d exp 3", mac_first); else passed++;
    total++; if (qf.size() !== 9) $display("FAIL basic_mac_count got %0d exp 9", qf.size()); else passed++;
    for (int i = 0; i < 9 && i < qf.size(); i++) begin
      total++; if (qf[i] !== ef[i] || qi[i] !== ei[i] || qc[i] !== ec[i])
        $display("FAIL basic_addr[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", i, qf[i], qi[i], qc[i], ef[i], ei[i], ec[i]);
      else passed++;
    end
    total++; if (pv_cnt !== 3 || pv_rise !== 3) $display("FAIL basic_psum got %0d/%0d exp 3/3", pv_cnt, pv_rise); else passed++;
    total++; if (done_cyc !== 18) $display("FAIL basic_done_cyc got %0d exp 18", done_cyc); else passed++;
    total++; if (busy_after !== 0) $display("FAIL basic_busy_after got %0d exp 0", busy_after); else passed++;
  endtask

  task automatic test_stride2();
    sel = 1;
    run_pass(0, 0, 0, 0, 1'b0);
    total++; if (qi.size() !== 9) $display("FAIL s2_mac_count got %0d exp 9", qi.size()); else passed++;
    for (int i = 0; i < 9 && i < qi.size(); i++) begin
      total++; if (qf[i] !== ef[i] || qi[i] !== ei2[i])
        $display("FAIL s2_addr[%0d] got (%0d,%0d) exp (%0d,%0d)", i, qf[i], qi[i], ef[i], ei2[i]);
      else passed++;
    end
    total++; if (done_cyc !== 18) $display("FAIL s2_done_cyc got %0d exp 18", done_cyc); else passed++;
  endtask

  task automatic test_load_delay();
    sel = 0;
    run_pass(5, 3, 0, 0, 1'b0);
    total++; if (sf_cnt !== 1 || si_cnt !== 1)
      $display("FAIL dly_start_pulses got %0d/%0d exp 1/1", sf_cnt, si_cnt); else passed++;
    total++; if (si_cyc !== 7) $display("FAIL dly_start_ifmap_cyc got %0d exp 7", si_cyc); else passed++;
    total++; if (mac_first !== 11) $display("FAIL dly_mac_first got %0d exp 11", mac_first); else passed++;
    total++; if (done_cyc !== 26) $display("FAIL dly_done_cyc got %0d exp 26", done_cyc); else passed++;
  endtask

  task automatic test_stall();
    sel = 0;
    run_pass(0, 0, 2, 4, 1'b0);
    total++; if (pv_max !== 5) $display("FAIL stall_valid_run got %0d exp 5", pv_max); else passed++;
    total++; if (pv_cnt !== 7) $display("FAIL stall_valid_total got %0d exp 7", pv_cnt); else passed++;
    total++; if (mac_stall_bad !== 0) $display("FAIL stall_mac_en got %0d exp 0", mac_stall_bad); else passed++;
    total++; if (qf.size() !== 9) $display("FAIL stall_mac_count got %0d exp 9", qf.size()); else passed++;
    for (int i = 0; i < 9 && i < qf.size(); i++) begin
      total++; if (qf[i] !== ef[i] || qi[i] !== ei[i])
        $display("FAIL stall_addr[%0d] got (%0d,%0d) exp (%0d,%0d)", i, qf[i], qi[i], ef[i], ei[i]);
      else passed++;
    end
    total++; if (done_cyc !== 22) $display("FAIL stall_done_cyc got %0d exp 22", done_cyc); else passed++;
  endtask

  task automatic test_reset_mid();
    int macs;
    sel = 0; macs = 0;
    filt_done = 1'b1; ifmap_done = 1'b1; psum_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 20 && macs < 2; c++) begin
      tick();
      start = 1'b0;
      if (m_me) macs++;
    end
    total++; if (macs !== 2) $display("FAIL rstmid_reach_mac got %0d exp 2", macs); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({sf0, si0, rc0, fa0, ia0, me0, ac0, pv0, bz0, dn0} !== '0)
      $display("FAIL rstmid_outputs got %b exp 0", {sf0, si0, rc0, fa0, ia0, me0, ac0, pv0, bz0, dn0}); else passed++;
    tick();
    run_pass(0, 0, 0, 0, 1'b0);
    total++; if (sf_cyc !== 1) $display("FAIL rstmid_replay_sf got %0d exp 1", sf_cyc); else passed++;
    total++; if (qf.size() !== 9 || qi.size() !== 9 || qi[qi.size()-1] !== 4)
      $display("FAIL rstmid_replay_macs got %0d exp 9", qf.size()); else passed++;
    total++; if (done_cyc !== 18) $display("FAIL rstmid_replay_done got %0d exp 18", done_cyc); else passed++;
  endtask

  task automatic test_repulse();
    sel = 0;
    run_pass(0, 0, 0, 0, 1'b1);
    total++; if (sf_cnt !== 1) $display("FAIL repulse_start_filt got %0d exp 1", sf_cnt); else passed++;
    total++; if (done_cyc !== 18) $display("FAIL repulse_done_cyc got %0d exp 18", done_cyc); else passed++;
    total++; if (done_cnt !== 1 || rc_bad !== 0)
      $display("FAIL repulse_done_rdclr got %0d/%0d exp 1/0", done_cnt, rc_bad); else passed++;
    total++; if (busy_after !== 0) $display("FAIL repulse_busy_after got %0d exp 0", busy_after); else passed++;
  endtask

  task automatic test_filt1();
    sel = 2;
    run_pass(0, 0, 0, 0, 1'b0);
    total++; if (qf.size() !== 1) $display("FAIL f1_mac_count got %0d exp 1", qf.size()); else passed++;
    total++; if (qf.size() > 0 && (qf[0] !== 0 || qi[0] !== 0 || qc[0] !== 1))
      $display("FAIL f1_mac got (%0d,%0d,%0d) exp (0,0,1)", qf[0], qi[0], qc[0]); else passed++;
    total++; if (pv_cnt !== 1) $display("FAIL f1_psum got %0d exp 1", pv_cnt); else passed++;
    total++; if (done_cyc !== 6) $display("FAIL f1_done_cyc got %0d exp 6", done_cyc); else passed++;
  endtask

  initial begin
    passed = 0; total = 0; sel = 0;
    rst = 1'b1; start = 1'b0; filt_done = 1'b0; ifmap_done = 1'b0; psum_ready = 1'b1;
    test_reset();
    test_basic();
    tick();
    test_stride2();
    tick();
    test_load_delay();
    tick();
    test_stall();
    tick();
    test_reset_mid();
    tick();
    test_repulse();
    tick();
    test_filt1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
